// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the IF/ID/EX pipeline control path: FSM state encoding,
// register-specifier width and the bundle of pipeline-register controls.
package pipe_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   // One bit per pipeline-register control, driven as a group each cycle.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_clear;
      logic idex_en;
      logic idex_clear;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clear: 1'b0,
                                  idex_en: 1'b1, idex_clear: 1'b0};
   localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clear: 1'b0,
                                     idex_en: 1'b0, idex_clear: 1'b0};
   localparam ctrl_t CTRL_FLUSH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clear: 1'b1,
                                    idex_en: 1'b1, idex_clear: 1'b1};
   localparam ctrl_t CTRL_LOADUSE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clear: 1'b0,
                                      idex_en: 1'b1, idex_clear: 1'b1};
   localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clear: 1'b1,
                                    idex_en: 1'b0, idex_clear: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; asynchronously
// cleared by an active-low reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;
   logic         w_at_max;

   assign w_at_max = (r_count == {W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (inc && !w_at_max) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flow controller for the 3-stage pipeline: load-use stalls, taken
// branch flushes, memory-wait freeze, halt, plus a saturating stall counter.
module pipe_hazard_ctrl #(
   parameter int REG_W        = pipe_ctrl_pkg::REG_W,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [REG_W-1:0]           id_rs1,
   input  logic [REG_W-1:0]           id_rs2,
   input  logic                       id_use_rs1,
   input  logic                       id_use_rs2,
   input  logic [REG_W-1:0]           ex_rd,
   input  logic                       ex_is_load,
   input  logic                       ex_branch_tkn,
   input  logic                       mem_busy,
   input  logic                       halt_req,
   output logic                       pc_en,
   output logic                       ifid_en,
   output logic                       ifid_clear,
   output logic                       idex_en,
   output logic                       idex_clear,
   output logic                       halted,
   output logic [CNT_W-1:0]           stall_cnt,
   output pipe_ctrl_pkg::state_t      dbg_state
);

   import pipe_ctrl_pkg::*;

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [FC_W-1:0]   r_flush_cnt;
   logic [FC_W-1:0]   w_flush_nxt;
   logic              r_halted;
   ctrl_t             w_ctrl;
   logic              w_hazard;
   logic              w_stall_inc;

   // Register 0 is hard-wired zero, so a load targeting it never stalls.
   function automatic logic load_use_hit(
      input logic             is_load,
      input logic [REG_W-1:0] rd,
      input logic [REG_W-1:0] rs1,
      input logic             use1,
      input logic [REG_W-1:0] rs2,
      input logic             use2
   );
      logic hit1;
      logic hit2;
      hit1 = use1 && (rs1 == rd);
      hit2 = use2 && (rs2 == rd);
      return is_load && (rd != '0) && (hit1 || hit2);
   endfunction

   assign w_hazard = load_use_hit(ex_is_load, ex_rd, id_rs1, id_use_rs1,
                                  id_rs2, id_use_rs2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= '0;
         r_halted    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_nxt;
         r_halted    <= (w_state_nxt == ST_HALT);
      end
   end

   always_comb begin
      w_ctrl      = CTRL_RUN;
      w_state_nxt = r_state;
      w_flush_nxt = r_flush_cnt;
      w_stall_inc = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (halt_req) begin
               w_ctrl      = CTRL_FREEZE;
               w_state_nxt = ST_HALT;
            end else if (mem_busy) begin
               w_ctrl      = CTRL_FREEZE;
               w_stall_inc = 1'b1;
            end else if (ex_branch_tkn) begin
               w_ctrl = CTRL_FLUSH;
               if (FLUSH_CYCLES > 1) begin
                  w_state_nxt = ST_FLUSH;
                  w_flush_nxt = FC_LOAD;
               end
            end else if (w_hazard) begin
               w_ctrl      = CTRL_LOADUSE;
               w_stall_inc = 1'b1;
            end
         end
         // EX holds a bubble here, so branch and halt inputs are not acted on.
         ST_FLUSH: begin
            if (mem_busy) begin
               w_ctrl      = CTRL_FREEZE;
               w_stall_inc = 1'b1;
            end else begin
               w_ctrl      = CTRL_FLUSH;
               w_flush_nxt = r_flush_cnt - FC_ONE;
               if (r_flush_cnt == FC_ONE) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_HALT: begin
            w_ctrl = CTRL_FREEZE;
         end
         default: begin
            w_ctrl      = CTRL_FREEZE;
            w_state_nxt = ST_RUN;
         end
      endcase
      if (!rst_n) begin
         w_ctrl = CTRL_RESET;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_stall_inc),
      .count (stall_cnt)
   );

   assign pc_en      = w_ctrl.pc_en;
   assign ifid_en    = w_ctrl.ifid_en;
   assign ifid_clear = w_ctrl.ifid_clear;
   assign idex_en    = w_ctrl.idex_en;
   assign idex_clear = w_ctrl.idex_clear;
   assign halted     = r_halted;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (FLUSH_CYCLES=1/CNT_W=16 and
// FLUSH_CYCLES=2/CNT_W=4) share inputs and are compared to a per-instance model.
module tb_pipe_hazard_ctrl;

   import pipe_ctrl_pkg::*;

   localparam int FC_A = 1;
   localparam int CW_A = 16;
   localparam int FC_B = 2;
   localparam int CW_B = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [REG_W-1:0] id_rs1 = '0;
   logic [REG_W-1:0] id_rs2 = '0;
   logic             id_use_rs1 = 1'b0;
   logic             id_use_rs2 = 1'b0;
   logic [REG_W-1:0] ex_rd = '0;
   logic             ex_is_load = 1'b0;
   logic             ex_branch_tkn = 1'b0;
   logic             mem_busy = 1'b0;
   logic             halt_req = 1'b0;

   logic [1:0]       pc_en, ifid_en, ifid_clear, idex_en, idex_clear, halted;
   logic [CW_A-1:0]  cnt_a;
   logic [CW_B-1:0]  cnt_b;
   state_t           st_a, st_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model: mode 0 = running, 1 = flushing, 2 = halted.
   int m_mode [2];
   int m_left [2];
   int m_stalls [2];
   int fc [2]   = '{FC_A, FC_B};
   int cmax [2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(FC_A), .CNT_W(CW_A)) u_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_is_load(ex_is_load), .ex_branch_tkn(ex_branch_tkn), .mem_busy(mem_busy),
      .halt_req(halt_req), .pc_en(pc_en[0]), .ifid_en(ifid_en[0]),
      .ifid_clear(ifid_clear[0]), .idex_en(idex_en[0]), .idex_clear(idex_clear[0]),
      .halted(halted[0]), .stall_cnt(cnt_a), .dbg_state(st_a)
   );

   pipe_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(FC_B), .CNT_W(CW_B)) u_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_is_load(ex_is_load), .ex_branch_tkn(ex_branch_tkn), .mem_busy(mem_busy),
      .halt_req(halt_req), .pc_en(pc_en[1]), .ifid_en(ifid_en[1]),
      .ifid_clear(ifid_clear[1]), .idex_en(idex_en[1]), .idex_clear(idex_clear[1]),
      .halted(halted[1]), .stall_cnt(cnt_b), .dbg_state(st_b)
   );

   function automatic bit load_use();
      return ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
   endfunction

   // Expected {pc_en, ifid_en, ifid_clear, idex_en, idex_clear}.
   function automatic logic [4:0] exp_ctl(int k);
      if (!rst_n) return 5'b00101;
      if (m_mode[k] == 2) return 5'b00000;
      if (m_mode[k] == 1) return mem_busy ? 5'b00000 : 5'b11111;
      if (halt_req || mem_busy) return 5'b00000;
      if (ex_branch_tkn) return 5'b11111;
      if (load_use()) return 5'b00011;
      return 5'b11010;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k]   = 0;
         m_left[k]   = 0;
         m_stalls[k] = 0;
      end
   endtask

   task automatic model_step(int k);
      case (m_mode[k])
         0: begin
            if (halt_req) m_mode[k] = 2;
            else if (mem_busy) m_stalls[k]++;
            else if (ex_branch_tkn) begin
               if (fc[k] > 1) begin
                  m_mode[k] = 1;
                  m_left[k] = fc[k] - 1;
               end
            end else if (load_use()) m_stalls[k]++;
         end
         1: begin
            if (mem_busy) m_stalls[k]++;
            else begin
               m_left[k]--;
               if (m_left[k] == 0) m_mode[k] = 0;
            end
         end
         default: ;
      endcase
   endtask

   task automatic chk(input string tag, input int k, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", tag, k, cyc, obs, exp);
      end
   endtask

   task automatic cycle();
      logic [4:0] obs;
      int         sat;
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int k = 0; k < 2; k++) begin
         obs = {pc_en[k], ifid_en[k], ifid_clear[k], idex_en[k], idex_clear[k]};
         chk("ctl", k, 32'(obs), 32'(exp_ctl(k)));
         chk("halted", k, 32'(halted[k]), 32'(m_mode[k] == 2));
         sat = (m_stalls[k] > cmax[k]) ? cmax[k] : m_stalls[k];
         chk("stall_cnt", k, (k == 0) ? 32'(cnt_a) : 32'(cnt_b), 32'(sat));
         chk("state", k, (k == 0) ? 32'(st_a) : 32'(st_b), 32'(m_mode[k]));
      end
      @(posedge clk);
      if (rst_n) begin
         model_step(0);
         model_step(1);
      end
      #1;
      cyc++;
   endtask

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = '0; ex_is_load = 1'b0; ex_branch_tkn = 1'b0;
      mem_busy = 1'b0; halt_req = 1'b0;
   endtask

   task automatic set_load_use(input logic [REG_W-1:0] rd);
      ex_is_load = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
      id_rs1 = 5'd9; id_use_rs1 = 1'b1;
   endtask

   initial begin
      model_reset();
      // Power-on reset, then a reset landing while instance B is flushing.
      cycle(); cycle();
      rst_n = 1'b1;
      cycle(); cycle();
      ex_branch_tkn = 1'b1; cycle();
      idle(); rst_n = 1'b0; cycle();
      rst_n = 1'b1; cycle();

      // Load-use through rs2, then the same with rd=0, then through rs1.
      set_load_use(5'd5); cycle();
      idle(); cycle();
      set_load_use(5'd0); cycle();
      idle(); ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; cycle();
      id_use_rs1 = 1'b0; cycle();
      idle(); cycle();

      // Branch with memory wait in the second flush cycle.
      ex_branch_tkn = 1'b1; cycle();
      idle(); mem_busy = 1'b1; cycle();
      mem_busy = 1'b0; cycle();
      cycle();

      // Busy + branch + load-use together, then busy drops with EX held.
      set_load_use(5'd5); ex_branch_tkn = 1'b1; mem_busy = 1'b1; cycle(); cycle();
      mem_busy = 1'b0; cycle();
      idle(); cycle(); cycle();

      // Twenty busy cycles saturate the 4-bit counter.
      mem_busy = 1'b1;
      for (int i = 0; i < 20; i++) cycle();
      idle(); cycle();

      // Halt, then activity that must be ignored until reset.
      halt_req = 1'b1; cycle();
      halt_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ex_branch_tkn = 1'($urandom_range(0, 1));
         mem_busy = 1'($urandom_range(0, 1));
         set_load_use(5'd5);
         cycle();
      end
      idle(); rst_n = 1'b0; cycle();
      rst_n = 1'b1; cycle();

      // Randomized traffic with small register range to provoke hazards.
      for (int i = 0; i < 600; i++) begin
         id_rs1 = REG_W'($urandom_range(0, 3));
         id_rs2 = REG_W'($urandom_range(0, 3));
         id_use_rs1 = 1'($urandom_range(0, 1));
         id_use_rs2 = 1'($urandom_range(0, 1));
         ex_rd = REG_W'($urandom_range(0, 3));
         ex_is_load = 1'($urandom_range(0, 1));
         ex_branch_tkn = ($urandom_range(0, 5) == 0);
         mem_busy = ($urandom_range(0, 4) == 0);
         halt_req = ($urandom_range(0, 59) == 0);
         rst_n = ($urandom_range(0, 39) != 0);
         cycle();
      end
      idle(); rst_n = 1'b1; cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
